// File: rtl/param_divider.sv
// Iterative restoring integer divider, signed or unsigned, producing RADIX_LOG2
// quotient bits per cycle behind a valid/ready handshake with flush support.
module param_divider #(
  parameter int WIDTH      = 32,
  parameter int RADIX_LOG2 = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             div_valid,
  output logic             div_ready,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             cancel,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [1:0]       state
);

  localparam int ITER = WIDTH / RADIX_LOG2;
  localparam int CW   = $clog2(ITER);

  typedef enum logic [1:0] {
    WAITING = 2'd0,
    LOAD    = 2'd1,
    DIVIDE  = 2'd2,
    RETURN  = 2'd3
  } divide_state_t;

  // Handshake: an operand transfer happens on a rising edge where
  // div_valid & div_ready & !cancel; a result transfer happens where
  // result_valid & result_ready & !cancel. Cancel always wins.
  divide_state_t    cur;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic             sgn_reg, q_neg, r_neg;
  logic [WIDTH-1:0] dvd, dsr;
  logic [WIDTH:0]   pr;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   pr_nxt;
  logic [WIDTH-1:0] dvd_nxt;

  assign state = cur;
  assign a_abs = (sgn_reg && a_reg[WIDTH-1]) ? -a_reg : a_reg;
  assign b_abs = (sgn_reg && b_reg[WIDTH-1]) ? -b_reg : b_reg;

  // Quotient bits shift into the bottom of dvd as dividend bits leave the top.
  always_comb begin
    logic [WIDTH:0]   sh;
    logic [WIDTH+1:0] diff;
    pr_nxt  = pr;
    dvd_nxt = dvd;
    sh      = '0;
    diff    = '0;
    for (int i = 0; i < RADIX_LOG2; i++) begin
      sh      = (pr_nxt << 1) | {{WIDTH{1'b0}}, dvd_nxt[WIDTH-1]};
      diff    = {1'b0, sh} - {2'b00, dsr};
      dvd_nxt = {dvd_nxt[WIDTH-2:0], ~diff[WIDTH+1]};
      pr_nxt  = diff[WIDTH+1] ? sh : diff[WIDTH:0];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cur          <= WAITING;
      div_ready    <= 1'b1;
      result_valid <= 1'b0;
      quotient     <= '0;
      remainder    <= '0;
      div_by_zero  <= 1'b0;
      a_reg        <= '0;
      b_reg        <= '0;
      sgn_reg      <= 1'b0;
      q_neg        <= 1'b0;
      r_neg        <= 1'b0;
      dvd          <= '0;
      dsr          <= '0;
      pr           <= '0;
      cnt          <= '0;
    end else if (cancel) begin
      cur          <= WAITING;
      div_ready    <= 1'b1;
      result_valid <= 1'b0;
    end else begin
      case (cur)
        WAITING: begin
          if (div_valid) begin
            a_reg     <= dividend;
            b_reg     <= divisor;
            sgn_reg   <= div_signed;
            div_ready <= 1'b0;
            cur       <= LOAD;
          end
        end
        LOAD: begin
          q_neg <= sgn_reg & (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]);
          r_neg <= sgn_reg & a_reg[WIDTH-1];
          dvd   <= a_abs;
          dsr   <= b_abs;
          pr    <= '0;
          cnt   <= CW'(ITER - 1);
          if (b_reg == '0) begin
            quotient     <= '1;
            remainder    <= a_reg;
            div_by_zero  <= 1'b1;
            result_valid <= 1'b1;
            cur          <= RETURN;
          end else begin
            cur <= DIVIDE;
          end
        end
        DIVIDE: begin
          dvd <= dvd_nxt;
          pr  <= pr_nxt;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            quotient     <= q_neg ? -dvd_nxt : dvd_nxt;
            remainder    <= WIDTH'(r_neg ? -pr_nxt : pr_nxt);
            div_by_zero  <= 1'b0;
            result_valid <= 1'b1;
            cur          <= RETURN;
          end
        end
        RETURN: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            div_ready    <= 1'b1;
            cur          <= WAITING;
          end
        end
        default: begin
          cur       <= WAITING;
          div_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
